tid_issuer: RTL and testbench

// - Ingress end of the in-order return path: stamps each host transaction with a sequential tid
//   (D_L LSBs used as reorder-ram address) before it enters the out-of-order SHA/verify pipeline.
// - Enforces credit flow control so the matching reorder buffer can never be overrun.
// - Credits return one per transaction popped in order at the egress end.

---
 rtl/tid_pkg.sv | 19 +
 rtl/tid_skid.sv | 71 +++++++
 rtl/tid_issuer.sv | 111 +++++++++++
 tb/tb_tid_issuer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tid_pkg.sv
// Shared definitions for the tid issuer and the matching egress reorder buffer.
// Both ends must agree on the entry layout and on the default depth.
package tid_pkg;

    localparam int TID_W       = 32;
    localparam int TID_D       = 16;
    localparam int TID_DL      = $clog2(TID_D);
    localparam int TID_MAX_OUT = TID_D - 1;
    localparam int TID_SEQ_W   = 32;

    typedef logic [TID_DL-1:0] tid_t;

    typedef struct packed {
        tid_t                 tid;
        logic [TID_SEQ_W-1:0] seq;
        logic [TID_W-1:0]     d;
    } tid_entry_t;

endpackage

// File: rtl/tid_skid.sv
// Small registered valid/ready buffer; the space flag is a register so that
// upstream ready never depends combinationally on downstream ready.
module tid_skid #(
    parameter type T     = logic,
    parameter int  DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_v,
    input  T     in_d,
    output logic space,
    output logic out_v,
    input  logic out_r,
    output T     out_d
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T               mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic           push;
    logic           pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push  = in_v & space;
    assign pop   = out_v & out_r;
    assign out_v = (count != '0);
    assign out_d = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            space  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            count <= count_next;
            space <= (count_next < CW'(DEPTH));
        end
    end

    // Storage carries no reset; out_v qualifies every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_d;
        end
    end

endmodule

// File: rtl/tid_issuer.sv
// Ingress end of the in-order return path: tags each transaction with a
// sequential tid/seq and gates acceptance on credits returned by the egress.
module tid_issuer
    import tid_pkg::*;
#(
    parameter int W       = TID_W,
    parameter int D       = TID_D,
    parameter int D_L     = $clog2(D),
    parameter int MAX_OUT = D - 1,
    parameter int SEQ_W   = TID_SEQ_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_v,
    output logic             i_r,
    input  logic [W-1:0]     i_d,
    output logic             o_v,
    input  logic             o_r,
    output logic [D_L-1:0]   o_a,
    output logic [W-1:0]     o_d,
    output logic [SEQ_W-1:0] o_seq,
    input  logic             c_v,
    output logic [D_L:0]     cnt,
    output logic             err
);

    localparam logic [D_L:0] MAX_CNT = (D_L + 1)'(MAX_OUT);

    typedef struct packed {
        logic [D_L-1:0]   tid;
        logic [SEQ_W-1:0] seq;
        logic [W-1:0]     d;
    } entry_t;

    logic [D_L-1:0]   tid_q;
    logic [SEQ_W-1:0] seq_q;
    logic [D_L:0]     cnt_q;
    logic [D_L:0]     cnt_next;
    logic             err_q;
    logic             err_next;
    logic             cnt_ok_q;
    logic             skid_space;
    logic             accept;
    entry_t           in_entry;
    entry_t           out_entry;

    // Both terms are flops, so i_r has no path from o_r or c_v.
    assign i_r    = cnt_ok_q & skid_space;
    assign accept = i_v & i_r;

    assign in_entry.tid = tid_q;
    assign in_entry.seq = seq_q;
    assign in_entry.d   = i_d;

    tid_skid #(
        .T     (entry_t),
        .DEPTH (2)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .in_v  (accept),
        .in_d  (in_entry),
        .space (skid_space),
        .out_v (o_v),
        .out_r (o_r),
        .out_d (out_entry)
    );

    assign o_a   = out_entry.tid;
    assign o_seq = out_entry.seq;
    assign o_d   = out_entry.d;
    assign cnt   = cnt_q;
    assign err   = err_q;

    // A credit arriving with nothing in flight is a protocol error; the count
    // is clamped at zero rather than wrapping.
    always_comb begin
        cnt_next = cnt_q;
        err_next = err_q;
        case ({accept, c_v})
            2'b10: cnt_next = cnt_q + 1'b1;
            2'b01: begin
                if (cnt_q == '0) begin
                    err_next = 1'b1;
                end else begin
                    cnt_next = cnt_q - 1'b1;
                end
            end
            default: cnt_next = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tid_q    <= '0;
            seq_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            cnt_ok_q <= 1'b0;
        end else begin
            if (accept) begin
                tid_q <= tid_q + 1'b1;
                seq_q <= seq_q + 1'b1;
            end
            cnt_q    <= cnt_next;
            err_q    <= err_next;
            cnt_ok_q <= (cnt_next < MAX_CNT);
        end
    end

endmodule

// File: tb/tb_tid_issuer.sv
// Directed self-checking bench for tid_issuer: credit limit, wrap, stall,
// error flag and mid-traffic reset, with hand-computed expectations.
module tb_tid_issuer;

    localparam int W     = 32;
    localparam int D     = 16;
    localparam int D_L   = 4;
    localparam int SEQ_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_v;
    logic             i_r;
    logic [W-1:0]     i_d;
    logic             o_v;
    logic             o_r;
    logic [D_L-1:0]   o_a;
    logic [W-1:0]     o_d;
    logic [SEQ_W-1:0] o_seq;
    logic             c_v;
    logic [D_L:0]     cnt;
    logic             err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        v;
        logic        r;
        logic        c;
        logic [31:0] d;
        logic        exp_ir;
        logic        exp_ov;
        logic [3:0]  exp_oa;
        logic [31:0] exp_od;
        logic [31:0] exp_seq;
        logic [4:0]  exp_cnt;
    } vec_t;

    vec_t vecs [10];

    tid_issuer #(
        .W       (W),
        .D       (D),
        .D_L     (D_L),
        .MAX_OUT (D - 1),
        .SEQ_W   (SEQ_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .i_v   (i_v),
        .i_r   (i_r),
        .i_d   (i_d),
        .o_v   (o_v),
        .o_r   (o_r),
        .o_a   (o_a),
        .o_d   (o_d),
        .o_seq (o_seq),
        .c_v   (c_v),
        .cnt   (cnt),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, then sample just after the clock edge.
    task automatic applyStimulus(input logic v, input logic r, input logic c, input logic [31:0] d);
        i_v = v;
        o_r = r;
        c_v = c;
        i_d = d;
        step();
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic waitReady(input string name);
        int n = 0;
        while (i_r !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        checkOutput(name, {63'd0, i_r}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1, 0, 0, 32'hA0, 1, 1, 4, 32'hA0, 36, 8};
        vecs[1] = '{1, 0, 0, 32'hA1, 0, 1, 4, 32'hA0, 36, 9};
        vecs[2] = '{1, 0, 0, 32'hA2, 0, 1, 4, 32'hA0, 36, 9};
        vecs[3] = '{1, 0, 0, 32'hA3, 0, 1, 4, 32'hA0, 36, 9};
        vecs[4] = '{1, 0, 0, 32'hA4, 0, 1, 4, 32'hA0, 36, 9};
        vecs[5] = '{0, 1, 0, 32'h00, 1, 1, 5, 32'hA1, 37, 9};
        vecs[6] = '{0, 1, 0, 32'h00, 1, 0, 0, 32'h00, 0, 9};
        vecs[7] = '{0, 1, 1, 32'h00, 1, 0, 0, 32'h00, 0, 8};
        vecs[8] = '{1, 1, 1, 32'hB0, 1, 1, 6, 32'hB0, 38, 8};
        vecs[9] = '{0, 1, 0, 32'h00, 1, 0, 0, 32'h00, 0, 8};

        rst = 1'b1;
        i_v = 1'b0;
        o_r = 1'b0;
        c_v = 1'b0;
        i_d = '0;
        step();
        step();
        checkOutput("reset_o_v", {63'd0, o_v}, 64'd0);
        checkOutput("reset_i_r", {63'd0, i_r}, 64'd0);
        checkOutput("reset_cnt", {59'd0, cnt}, 64'd0);
        checkOutput("reset_err", {63'd0, err}, 64'd0);

        rst = 1'b0;
        step();
        waitReady("ready_after_reset");

        // Fill to the credit limit with full throughput.
        applyStimulus(1, 1, 0, 32'd100);
        checkOutput("fill_o_v", {63'd0, o_v}, 64'd1);
        checkOutput("fill_o_a", {60'd0, o_a}, 64'd0);
        for (int k = 1; k < 15; k++) begin
            checkOutput("fill_i_r", {63'd0, i_r}, 64'd1);
            checkOutput("fill_cnt", {59'd0, cnt}, 64'(k));
            applyStimulus(1, 1, 0, 32'(100 + k));
            checkOutput("fill_o_a", {60'd0, o_a}, 64'(k));
            checkOutput("fill_o_d", {32'd0, o_d}, 64'(100 + k));
            checkOutput("fill_o_seq", {32'd0, o_seq}, 64'(k));
        end
        checkOutput("full_i_r", {63'd0, i_r}, 64'd0);
        checkOutput("full_cnt", {59'd0, cnt}, 64'd15);
        applyStimulus(1, 1, 0, 32'hDEAD);
        checkOutput("full_drained_o_v", {63'd0, o_v}, 64'd0);
        checkOutput("full_hold_i_r", {63'd0, i_r}, 64'd0);
        checkOutput("full_hold_cnt", {59'd0, cnt}, 64'd15);

        // One credit reopens exactly one slot, which gets tid 15.
        applyStimulus(1, 1, 1, 32'hDEAD);
        checkOutput("credit_cnt", {59'd0, cnt}, 64'd14);
        checkOutput("credit_i_r", {63'd0, i_r}, 64'd1);
        applyStimulus(1, 1, 0, 32'd115);
        checkOutput("tid15_o_a", {60'd0, o_a}, 64'd15);
        checkOutput("tid15_o_seq", {32'd0, o_seq}, 64'd15);
        checkOutput("tid15_i_r", {63'd0, i_r}, 64'd0);
        checkOutput("tid15_cnt", {59'd0, cnt}, 64'd15);
        applyStimulus(1, 1, 0, 32'hDEAD);
        checkOutput("one_more_o_v", {63'd0, o_v}, 64'd0);
        checkOutput("one_more_cnt", {59'd0, cnt}, 64'd15);

        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, 1, 32'd0);
        end
        checkOutput("drain7_cnt", {59'd0, cnt}, 64'd7);
        checkOutput("drain7_i_r", {63'd0, i_r}, 64'd1);

        // Accept and credit in the same cycle: count holds, tid wraps.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1, 1, 1, 32'(200 + k));
            checkOutput("steady_cnt", {59'd0, cnt}, 64'd7);
            checkOutput("steady_o_a", {60'd0, o_a}, 64'(k % 16));
            checkOutput("steady_o_seq", {32'd0, o_seq}, 64'(16 + k));
            checkOutput("steady_o_d", {32'd0, o_d}, 64'(200 + k));
        end
        applyStimulus(0, 1, 0, 32'd0);
        checkOutput("steady_end_o_v", {63'd0, o_v}, 64'd0);
        checkOutput("steady_end_cnt", {59'd0, cnt}, 64'd7);

        // Backpressure: two accepts fill the skid, outputs hold, drain in order.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].v, vecs[i].r, vecs[i].c, vecs[i].d);
            checkOutput("vec_i_r", {63'd0, i_r}, {63'd0, vecs[i].exp_ir});
            checkOutput("vec_o_v", {63'd0, o_v}, {63'd0, vecs[i].exp_ov});
            checkOutput("vec_cnt", {59'd0, cnt}, {59'd0, vecs[i].exp_cnt});
            if (vecs[i].exp_ov) begin
                checkOutput("vec_o_a", {60'd0, o_a}, {60'd0, vecs[i].exp_oa});
                checkOutput("vec_o_d", {32'd0, o_d}, {32'd0, vecs[i].exp_od});
                checkOutput("vec_o_seq", {32'd0, o_seq}, {32'd0, vecs[i].exp_seq});
            end
        end

        // Credit with nothing in flight sets the sticky error.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, 1, 32'd0);
        end
        checkOutput("empty_cnt", {59'd0, cnt}, 64'd0);
        checkOutput("empty_err", {63'd0, err}, 64'd0);
        applyStimulus(0, 1, 1, 32'd0);
        checkOutput("underflow_cnt", {59'd0, cnt}, 64'd0);
        checkOutput("underflow_err", {63'd0, err}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 1, 0, 32'(300 + k));
            checkOutput("sticky_err", {63'd0, err}, 64'd1);
            checkOutput("sticky_cnt", {59'd0, cnt}, 64'(k + 1));
            checkOutput("sticky_o_a", {60'd0, o_a}, 64'(7 + k));
        end
        applyStimulus(0, 1, 0, 32'd0);

        // Reset with traffic in flight and the skid full.
        applyStimulus(1, 0, 0, 32'd400);
        applyStimulus(1, 0, 0, 32'd401);
        checkOutput("pre_rst_cnt", {59'd0, cnt}, 64'd5);
        checkOutput("pre_rst_o_a", {60'd0, o_a}, 64'd10);
        checkOutput("pre_rst_i_r", {63'd0, i_r}, 64'd0);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 32'd0);
        checkOutput("rst_o_v", {63'd0, o_v}, 64'd0);
        checkOutput("rst_cnt", {59'd0, cnt}, 64'd0);
        checkOutput("rst_err", {63'd0, err}, 64'd0);
        checkOutput("rst_i_r", {63'd0, i_r}, 64'd0);
        rst = 1'b0;
        applyStimulus(0, 1, 0, 32'd0);
        waitReady("ready_after_rst");
        applyStimulus(1, 1, 0, 32'h55);
        i_v = 1'b0;
        checkOutput("post_rst_o_v", {63'd0, o_v}, 64'd1);
        checkOutput("post_rst_o_a", {60'd0, o_a}, 64'd0);
        checkOutput("post_rst_o_seq", {32'd0, o_seq}, 64'd0);
        checkOutput("post_rst_o_d", {32'd0, o_d}, 64'h55);
        checkOutput("post_rst_cnt", {59'd0, cnt}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
